fft_stage_sequencer: RTL

FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_addr_gen.sv | 31 +++
 rtl/fft_stage_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT stage sequencer.
// Defining FFT_SEQ_BITREV_READOUT_EN adds the READOUT state.
package fft_pkg;

`ifdef FFT_SEQ_BITREV_READOUT_EN
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, READOUT, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
`endif

  localparam int CTRL_FIRST = 0;
  localparam int CTRL_LAST  = 1;
  localparam int CTRL_W     = 2;

  // Reverses the low 'width' bits of value; higher result bits are zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r = (r << 1) | ((value >> i) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Radix-2 pair and twiddle address mapping for butterfly k of a given stage.
// Purely combinational; used for both the read and the write-back side.
module fft_addr_gen #(
  parameter int FFT_N   = 10,
  parameter int STAGE_W = 4
) (
  input  logic [STAGE_W-1:0] stage,
  input  logic [FFT_N-2:0]   k,
  output logic [FFT_N-1:0]   addr_a,
  output logic [FFT_N-1:0]   addr_b,
  output logic [FFT_N-2:0]   tw_addr
);

  localparam logic [FFT_N-1:0] HALF = FFT_N'(1) << (FFT_N-1);

  logic [FFT_N-1:0] span;
  logic [FFT_N-1:0] mask;
  logic [FFT_N-1:0] k_ext;

  // span is a power of two, so k/span and k mod span are a bit split:
  // the high part moves up one position to leave room for the partner bit.
  always_comb begin
    span    = HALF >> stage;
    mask    = span - FFT_N'(1);
    k_ext   = {1'b0, k};
    addr_a  = ((k_ext & ~mask) << 1) | (k_ext & mask);
    addr_b  = addr_a | span;
    tw_addr = (k & mask[FFT_N-2:0]) << stage;
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 FFT stage sequencer: issues N/2 butterflies per stage and
// waits for all write-backs before the next stage. Option: FFT_SEQ_BITREV_READOUT_EN.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int FFT_N  = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [FFT_N-1:0]  rd_addr_a,
  output logic [FFT_N-1:0]  rd_addr_b,
  output logic [FFT_N-2:0]  tw_addr,
  output logic              bf_iact,
  output logic [CTRL_W-1:0] bf_ictrl,
  output logic [FFT_N-2:0]  bf_addr,
  input  logic              bf_oact,
  input  logic [CTRL_W-1:0] bf_octrl,
  input  logic [FFT_N-2:0]  bf_oaddr,
  output logic              wr_en,
  output logic [FFT_N-1:0]  wr_addr_a,
  output logic [FFT_N-1:0]  wr_addr_b
`ifdef FFT_SEQ_BITREV_READOUT_EN
  ,
  output logic              ro_valid,
  output logic [FFT_N-1:0]  ro_addr,
  output logic              ro_last
`endif
);

  localparam int KW      = FFT_N - 1;
  localparam int STAGE_W = (FFT_N > 1) ? $clog2(FFT_N) : 1;
  localparam logic [STAGE_W-1:0] LAST_STAGE   = STAGE_W'(FFT_N - 1);
  localparam logic [FFT_N-1:0]   CNT_LAST_RET = (FFT_N'(1) << (FFT_N-1)) - FFT_N'(1);

  state_t             state, state_nxt;
  logic [STAGE_W-1:0] stage, stage_nxt;
  logic [KW-1:0]      k, k_nxt;
  logic [FFT_N-1:0]   cnt, cnt_nxt;
  logic [CTRL_W-1:0]  issue_ctrl;
  logic               wr_active;
  logic               last_return;

  logic              iact_dl [RD_LAT];
  logic [CTRL_W-1:0] ctrl_dl [RD_LAT];
  logic [KW-1:0]     addr_dl [RD_LAT];

  logic [FFT_N-1:0] rd_a, rd_b, wr_a, wr_b;
  logic [KW-1:0]    rd_tw, unused_wr_tw;
  logic             unused_octrl;

  // Stage completion is decided by the return count; the tag is informational.
  assign unused_octrl = ^bf_octrl;

  fft_addr_gen #(.FFT_N(FFT_N), .STAGE_W(STAGE_W)) u_rd_addr (
    .stage   (stage),
    .k       (k),
    .addr_a  (rd_a),
    .addr_b  (rd_b),
    .tw_addr (rd_tw)
  );

  fft_addr_gen #(.FFT_N(FFT_N), .STAGE_W(STAGE_W)) u_wr_addr (
    .stage   (stage),
    .k       (bf_oaddr),
    .addr_a  (wr_a),
    .addr_b  (wr_b),
    .tw_addr (unused_wr_tw)
  );

  assign wr_active   = (state == ISSUE || state == DRAIN) && !reset;
  assign last_return = bf_oact && (cnt == CNT_LAST_RET);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt  = state;
    stage_nxt  = stage;
    k_nxt      = k;
    cnt_nxt    = cnt;
    rd_en      = 1'b0;
    issue_ctrl = '0;
    if (wr_active && bf_oact) cnt_nxt = cnt + FFT_N'(1);
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ISSUE;
          stage_nxt = '0;
          k_nxt     = '0;
          cnt_nxt   = '0;
        end
      end
      ISSUE: begin
        rd_en                  = 1'b1;
        issue_ctrl[CTRL_FIRST] = (k == '0);
        issue_ctrl[CTRL_LAST]  = (k == '1);
        k_nxt                  = k + KW'(1);
        if (k == '1) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Leave on the cycle of the final return so the next read follows its write directly.
        if (last_return) begin
          cnt_nxt = '0;
          if (stage == LAST_STAGE) begin
`ifdef FFT_SEQ_BITREV_READOUT_EN
            state_nxt = READOUT;
`else
            state_nxt = DONE;
`endif
          end else begin
            state_nxt = ISSUE;
            stage_nxt = stage + STAGE_W'(1);
            k_nxt     = '0;
          end
        end
      end
`ifdef FFT_SEQ_BITREV_READOUT_EN
      READOUT: begin
        cnt_nxt = cnt + FFT_N'(1);
        if (cnt == '1) state_nxt = DONE;
      end
`endif
      DONE: begin
        state_nxt = IDLE;
        stage_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state <= IDLE;
      stage <= '0;
      k     <= '0;
      cnt   <= '0;
      // NOTE: the delay line is reset explicitly; a stale bf_iact after reset would issue a phantom butterfly.
      for (int i = 0; i < RD_LAT; i++) begin
        iact_dl[i] <= 1'b0;
        ctrl_dl[i] <= '0;
        addr_dl[i] <= '0;
      end
    end else begin
      state      <= state_nxt;
      stage      <= stage_nxt;
      k          <= k_nxt;
      cnt        <= cnt_nxt;
      iact_dl[0] <= rd_en;
      ctrl_dl[0] <= issue_ctrl;
      addr_dl[0] <= rd_en ? k : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        iact_dl[i] <= iact_dl[i-1];
        ctrl_dl[i] <= ctrl_dl[i-1];
        addr_dl[i] <= addr_dl[i-1];
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign rd_addr_a = rd_en ? rd_a  : '0;
  assign rd_addr_b = rd_en ? rd_b  : '0;
  assign tw_addr   = rd_en ? rd_tw : '0;
  assign bf_iact   = iact_dl[RD_LAT-1];
  assign bf_ictrl  = ctrl_dl[RD_LAT-1];
  assign bf_addr   = addr_dl[RD_LAT-1];
  assign wr_en     = wr_active && bf_oact;
  assign wr_addr_a = wr_en ? wr_a : '0;
  assign wr_addr_b = wr_en ? wr_b : '0;

`ifdef FFT_SEQ_BITREV_READOUT_EN
  assign ro_valid = (state == READOUT);
  assign ro_addr  = ro_valid ? FFT_N'(bit_reverse(32'(cnt), FFT_N)) : '0;
  assign ro_last  = ro_valid && (cnt == '1);
`endif

endmodule
